// File: rtl/seg_scan.sv
// Multiplexed hex seven-segment scanner with frame-synchronous double-buffered load.
// Optional leading-zero blanking: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic                  pend_v;
  logic [4*DIGITS-1:0]   pend_data;
  logic [DIGITS-1:0]     pend_dp;
  logic [4*DIGITS-1:0]   disp_data;
  logic [DIGITS-1:0]     disp_dp;
  logic                  wrap_q;

  logic                  tick;
  logic                  last;
  logic                  wrap;
  logic [3:0]            nib;
  logic [6:0]            glyph;

  assign tick = (pcnt == PW'(DIV - 1));
  assign last = (idx == IW'(DIGITS - 1));
  assign wrap = tick & last;
  assign nib  = disp_data[4*int'(idx) +: 4];

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              zrun;

  // Zero run from the top digit down; digit 0 always shows.
  always_comb begin
    blank = '0;
    zrun  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zrun     = zrun & (disp_data[4*k +: 4] == 4'h0);
      blank[k] = zrun & (k != 0);
    end
  end

  assign glyph = blank[idx] ? 7'h00 : dec7(nib);
`else
  assign glyph = dec7(nib);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      idx        <= '0;
      pend_v     <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
      wrap_q     <= 1'b0;
      seg        <= 8'h00;
      an         <= '0;
      frame_tick <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) idx <= last ? '0 : idx + 1'b1;

      if (wrap) begin
        if (load) begin
          disp_data <= data_in;
          disp_dp   <= dp_in;
        end else if (pend_v) begin
          disp_data <= pend_data;
          disp_dp   <= pend_dp;
        end
        pend_v <= 1'b0;
      end else if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        pend_v    <= 1'b1;
      end

      // frame_tick lines up with an returning to digit 0
      wrap_q     <= wrap;
      frame_tick <= wrap_q;
      an         <= DIGITS'(1) << idx;
      seg        <= {disp_dp[idx], glyph};
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan, DIGITS=4, DIV=4.
// Outputs sampled on the falling edge.
module tb_seg_scan;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  seg_scan #(.DIGITS(4), .DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam logic [7:0] D2_0050 = 8'h80;
  localparam logic [7:0] D3_0050 = 8'h00;
`else
  localparam logic [7:0] D2_0050 = 8'hBF;
  localparam logic [7:0] D3_0050 = 8'h3F;
`endif

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    data_in = '0;
    dp_in   = '0;
    step(3);
    chk("rst_seg", 16'(seg), 16'h00);
    chk("rst_an", 16'(an), 16'h0);
    chk("rst_ft", 16'(frame_tick), 16'h0);
    rst_n = 1'b1;

    step(1);
    chk("e1_an", 16'(an), 16'h1);
    chk("e1_seg", 16'(seg), 16'h3F);
    chk("e1_ft", 16'(frame_tick), 16'h0);
    step(15);
    chk("e16_an", 16'(an), 16'h8);
    chk("e16_ft", 16'(frame_tick), 16'h0);
    step(1);
    chk("e17_ft", 16'(frame_tick), 16'h1);
    chk("e17_an", 16'(an), 16'h1);
    step(1);
    chk("e18_ft", 16'(frame_tick), 16'h0);
    step(15);
    chk("e33_ft", 16'(frame_tick), 16'h1);

    load = 1'b1; data_in = 16'h1234; dp_in = 4'b0000;
    step(1);
    load = 1'b0;
    chk("mid_an", 16'(an), 16'h1);
    chk("mid_seg", 16'(seg), 16'h3F);
    step(6);
    chk("mid2_an", 16'(an), 16'h2);
    chk("mid2_seg", 16'(seg), 16'h3F);
    step(9);
    chk("f1_d0_an", 16'(an), 16'h1);
    chk("f1_d0", 16'(seg), 16'h66);
    step(3);
    chk("f1_d0_hold", 16'(seg), 16'h66);
    step(1);
    chk("f1_d1_an", 16'(an), 16'h2);
    chk("f1_d1", 16'(seg), 16'h4F);
    step(4);
    chk("f1_d2", 16'(seg), 16'h5B);
    step(4);
    chk("f1_d3_an", 16'(an), 16'h8);
    chk("f1_d3", 16'(seg), 16'h06);

    load = 1'b1; data_in = 16'hABCD;
    step(1);
    data_in = 16'hEF98;
    step(1);
    load = 1'b0;
    chk("f2_pre", 16'(seg), 16'h06);
    step(2);
    chk("f2_d0", 16'(seg), 16'h7F);
    step(4);
    chk("f2_d1", 16'(seg), 16'h6F);
    step(4);
    chk("f2_d2", 16'(seg), 16'h71);
    step(4);
    chk("f2_d3", 16'(seg), 16'h79);
    step(2);

    load = 1'b1; data_in = 16'h0050; dp_in = 4'b0100;
    step(1);
    load = 1'b0; dp_in = 4'b0000;
    chk("f3_pre_an", 16'(an), 16'h8);
    chk("f3_pre", 16'(seg), 16'h79);
    step(1);
    chk("f3_d0", 16'(seg), 16'h3F);
    step(4);
    chk("f3_d1", 16'(seg), 16'h6D);
    step(4);
    chk("f3_d2", 16'(seg), 16'(D2_0050));
    step(4);
    chk("f3_d3_an", 16'(an), 16'h8);
    chk("f3_d3", 16'(seg), 16'(D3_0050));

    step(1);
    load = 1'b1; data_in = 16'h7777;
    step(1);
    load = 1'b0;
    step(10);
    chk("r_pre_an", 16'(an), 16'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_seg", 16'(seg), 16'h00);
    chk("r_async_an", 16'(an), 16'h0);
    chk("r_async_ft", 16'(frame_tick), 16'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("r_e1_an", 16'(an), 16'h1);
    chk("r_e1_seg", 16'(seg), 16'h3F);
    step(16);
    chk("r_e17_ft", 16'(frame_tick), 16'h1);
    chk("r_e17_seg", 16'(seg), 16'h3F);
    step(4);
    chk("r_e21_an", 16'(an), 16'h2);
    chk("r_e21_seg", 16'(seg), 16'h3F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
